// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared widths, grid pitches and flat-index helpers for the
//               convolution unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int MAX_IN = 5;
    localparam int MAX_K  = 3;
    // Worst case 9 * 255 * 255 = 585225 fits in 20 bits.
    localparam int ACC_W  = 20;

    function automatic int img_idx(input int r, input int c);
        return r * MAX_IN + c;
    endfunction

    function automatic int ker_idx(input int r, input int c);
        return r * MAX_K + c;
    endfunction

    function automatic int res_idx(input int i, input int j);
        return i * MAX_IN + j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_mac.sv
// ============================================================================
// Module      : conv_window_mac
// Description : One output element: masked 3x3 window-by-kernel dot product,
//               wrapped or clamped to RES_W (CONV_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_mac
    import conv_pkg::*;
(
    input  logic [MAX_K*MAX_K*DATA_W-1:0] i_window,
    input  logic [MAX_K*MAX_K*DATA_W-1:0] i_kernel,
    input  logic [1:0]                    i_k_m,
    input  logic [1:0]                    i_k_n,
    output logic [RES_W-1:0]              o_result
);

    logic [ACC_W-1:0]    w_acc;
    logic [2*DATA_W-1:0] w_prod;

    always_comb begin
        w_acc  = '0;
        w_prod = '0;
        for (int a = 0; a < MAX_K; a++) begin
            for (int b = 0; b < MAX_K; b++) begin
                if ((2'(a) < i_k_m) && (2'(b) < i_k_n)) begin
                    w_prod = i_window[ker_idx(a, b)*DATA_W +: DATA_W]
                           * i_kernel[ker_idx(a, b)*DATA_W +: DATA_W];
                    w_acc  = w_acc + ACC_W'(w_prod);
                end
            end
        end
    end

`ifdef CONV_SATURATE_EN
    assign o_result = (|w_acc[ACC_W-1:RES_W]) ? {RES_W{1'b1}} : w_acc[RES_W-1:0];
`else
    logic w_unused_hi;
    assign w_unused_hi = |w_acc[ACC_W-1:RES_W];
    assign o_result    = w_acc[RES_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/convolution_unit.sv
// ============================================================================
// Module      : convolution_unit
// Description : Combinational valid-mode 2-D correlation (5x5 image, 3x3
//               kernel) with a registered MAC-cycle timing model.
//               Optional macro CONV_SATURATE_EN clamps results at 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module convolution_unit
    import conv_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2:0]                        in_m,
    input  logic [2:0]                        in_n,
    input  logic [1:0]                        k_m,
    input  logic [1:0]                        k_n,
    input  logic [MAX_IN*MAX_IN*DATA_W-1:0]   inputImage,
    input  logic [MAX_K*MAX_K*DATA_W-1:0]     kernelMatrix,
    output logic [2:0]                        out_m,
    output logic [2:0]                        out_n,
    output logic [MAX_IN*MAX_IN*RES_W-1:0]    convResult,
    output logic                              valid,
    output logic [9:0]                        cycleCount,
    output logic                              done,
    output logic                              dim_error
);

    logic             w_dim_error;
    logic [2:0]       w_out_m;
    logic [2:0]       w_out_n;
    logic [9:0]       w_total;
    logic [9:0]       r_cycle_count;
    logic             r_done;
    logic [RES_W-1:0] w_mac_res [MAX_K][MAX_K];

    assign w_dim_error = (in_m == 3'd0) || (in_m > 3'd5) ||
                         (in_n == 3'd0) || (in_n > 3'd5) ||
                         (k_m == 2'd0)  || (k_n == 2'd0) ||
                         ({1'b0, k_m} > in_m) || ({1'b0, k_n} > in_n);

    assign w_out_m = w_dim_error ? 3'd0 : (in_m - {1'b0, k_m} + 3'd1);
    assign w_out_n = w_dim_error ? 3'd0 : (in_n - {1'b0, k_n} + 3'd1);

    // Zero whenever dims are illegal, because out_m/out_n are forced to 0.
    assign w_total = 10'(w_out_m) * 10'(w_out_n) * 10'(k_m) * 10'(k_n);

    for (genvar gr = 0; gr < MAX_K; gr++) begin : g_row
        for (genvar gc = 0; gc < MAX_K; gc++) begin : g_col
            logic [MAX_K*MAX_K*DATA_W-1:0] w_window;

            for (genvar wr = 0; wr < MAX_K; wr++) begin : g_win_r
                for (genvar wc = 0; wc < MAX_K; wc++) begin : g_win_c
                    assign w_window[ker_idx(wr, wc)*DATA_W +: DATA_W] =
                        inputImage[img_idx(gr + wr, gc + wc)*DATA_W +: DATA_W];
                end
            end

            conv_window_mac u_mac (
                .i_window (w_window),
                .i_kernel (kernelMatrix),
                .i_k_m    (k_m),
                .i_k_n    (k_n),
                .o_result (w_mac_res[gr][gc])
            );
        end
    end

    for (genvar gi = 0; gi < MAX_IN; gi++) begin : g_res_row
        for (genvar gj = 0; gj < MAX_IN; gj++) begin : g_res_col
            if (gi < MAX_K && gj < MAX_K) begin : g_active
                assign convResult[res_idx(gi, gj)*RES_W +: RES_W] =
                    ((w_out_m > 3'(gi)) && (w_out_n > 3'(gj))) ? w_mac_res[gi][gj] : '0;
            end else begin : g_zero
                assign convResult[res_idx(gi, gj)*RES_W +: RES_W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle_count <= '0;
            r_done        <= 1'b0;
        end else if (!w_dim_error) begin
            if (r_cycle_count < w_total) begin
                r_cycle_count <= r_cycle_count + 10'd1;
                if (r_cycle_count + 10'd1 >= w_total) begin
                    r_done <= 1'b1;
                end
            end else begin
                r_done <= 1'b1;
            end
        end
    end

    assign out_m      = w_out_m;
    assign out_n      = w_out_n;
    assign valid      = !w_dim_error;
    assign dim_error  = w_dim_error;
    assign cycleCount = r_cycle_count;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_convolution_unit.sv
// ============================================================================
// Module      : tb_convolution_unit
// Description : Directed self-checking bench for convolution_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_convolution_unit;

    logic         clk;
    logic         clk_en;
    logic         reset;
    logic [2:0]   in_m, in_n;
    logic [1:0]   k_m, k_n;
    logic [199:0] img;
    logic [71:0]  ker;
    logic [2:0]   out_m, out_n;
    logic [399:0] res;
    logic         valid;
    logic [9:0]   cycle_count;
    logic         done;
    logic         dim_error;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_res [5][5];

    convolution_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_m         (in_m),
        .in_n         (in_n),
        .k_m          (k_m),
        .k_n          (k_n),
        .inputImage   (img),
        .kernelMatrix (ker),
        .out_m        (out_m),
        .out_n        (out_n),
        .convResult   (res),
        .valid        (valid),
        .cycleCount   (cycle_count),
        .done         (done),
        .dim_error    (dim_error)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_grid(input string tag);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                check($sformatf("%s_r%0d%0d", tag, i, j),
                      32'(res[(i*5+j)*16 +: 16]), 32'(exp_res[i][j]));
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                exp_res[i][j] = 16'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_img(input int r, input int c, input logic [7:0] v);
        img[(r*5+c)*8 +: 8] = v;
    endtask

    task automatic set_ker(input int r, input int c, input logic [7:0] v);
        ker[(r*3+c)*8 +: 8] = v;
    endtask

    initial begin
        clk_en = 1'b0;
        reset  = 1'b0;

        // 4x4 ramp image, 2x2 ones kernel, reset low, clock stopped
        img = '0; ker = '0;
        in_m = 3'd4; in_n = 3'd4; k_m = 2'd2; k_n = 2'd2;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                set_img(r, c, 8'(r*4 + c + 1));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                set_ker(r, c, 8'd1);
        #20;
        clear_exp();
        exp_res[0][0] = 16'd14; exp_res[0][1] = 16'd18; exp_res[0][2] = 16'd22;
        exp_res[1][0] = 16'd30; exp_res[1][1] = 16'd34; exp_res[1][2] = 16'd38;
        exp_res[2][0] = 16'd46; exp_res[2][1] = 16'd50; exp_res[2][2] = 16'd54;
        check("ramp_valid", 32'(valid), 32'd1);
        check("ramp_dim_error", 32'(dim_error), 32'd0);
        check("ramp_out_m", 32'(out_m), 32'd3);
        check("ramp_out_n", 32'(out_n), 32'd3);
        check_grid("ramp_res");
        check("rst_count", 32'(cycle_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Release reset and run past TOTAL = 3*3*2*2 = 36
        reset  = 1'b1;
        clk_en = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            check($sformatf("run_count_%0d", n), 32'(cycle_count), (n < 36) ? 32'(n) : 32'd36);
            check($sformatf("run_done_%0d", n), 32'(done), (n >= 36) ? 32'd1 : 32'd0);
        end
        reset = 1'b0;
        tick();
        check("rerst_count", 32'(cycle_count), 32'd0);
        check("rerst_done", 32'(done), 32'd0);

        // Illegal dimension combinations
        clear_exp();
        for (int t = 0; t < 3; t++) begin
            in_m = 3'd4; in_n = 3'd4; k_m = 2'd2; k_n = 2'd2;
            if (t == 0) begin in_m = 3'd2; k_m = 2'd3; end
            if (t == 1) in_n = 3'd6;
            if (t == 2) k_n = 2'd0;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            check($sformatf("err%0d_dim_error", t), 32'(dim_error), 32'd1);
            check($sformatf("err%0d_valid", t), 32'(valid), 32'd0);
            check($sformatf("err%0d_out_m", t), 32'(out_m), 32'd0);
            check($sformatf("err%0d_out_n", t), 32'(out_n), 32'd0);
            check_grid($sformatf("err%0d_res", t));
            tick(); tick(); tick();
            check($sformatf("err%0d_count", t), 32'(cycle_count), 32'd0);
            check($sformatf("err%0d_done", t), 32'(done), 32'd0);
        end

        // Full-scale 5x5 x 3x3, TOTAL = 81
        reset = 1'b0;
        tick();
        in_m = 3'd5; in_n = 3'd5; k_m = 2'd3; k_n = 2'd3;
        img = {200{1'b1}};
        ker = {72{1'b1}};
        clear_exp();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
`ifdef CONV_SATURATE_EN
                exp_res[i][j] = 16'd65535;
`else
                exp_res[i][j] = 16'd60937;
`endif
        #1;
        check("full_out_m", 32'(out_m), 32'd3);
        check("full_out_n", 32'(out_n), 32'd3);
        check_grid("full_res");
        reset = 1'b1;
        for (int n = 0; n < 80; n++) tick();
        check("full_count_80", 32'(cycle_count), 32'd80);
        check("full_done_80", 32'(done), 32'd0);
        tick();
        check("full_count_81", 32'(cycle_count), 32'd81);
        check("full_done_81", 32'(done), 32'd1);
        tick();
        check("full_count_hold", 32'(cycle_count), 32'd81);
        check("full_done_hold", 32'(done), 32'd1);

        // 3x3 ramp, 1x1 kernel = 2, garbage in unused bits
        img = {25{8'hA5}};
        ker = {9{8'h5A}};
        in_m = 3'd3; in_n = 3'd3; k_m = 2'd1; k_n = 2'd1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                set_img(r, c, 8'(r*3 + c + 1));
        set_ker(0, 0, 8'd2);
        clear_exp();
        exp_res[0][0] = 16'd2;  exp_res[0][1] = 16'd4;  exp_res[0][2] = 16'd6;
        exp_res[1][0] = 16'd8;  exp_res[1][1] = 16'd10; exp_res[1][2] = 16'd12;
        exp_res[2][0] = 16'd14; exp_res[2][1] = 16'd16; exp_res[2][2] = 16'd18;
        #1;
        check("k1_out_m", 32'(out_m), 32'd3);
        check("k1_out_n", 32'(out_n), 32'd3);
        check_grid("k1_res");

        // Asymmetric kernel on a 1x2 image: no flip gives 3, a flip would give 5
        img = {25{8'h77}};
        ker = {9{8'h33}};
        in_m = 3'd1; in_n = 3'd2; k_m = 2'd1; k_n = 2'd2;
        set_img(0, 0, 8'd3); set_img(0, 1, 8'd5);
        set_ker(0, 0, 8'd1); set_ker(0, 1, 8'd0);
        clear_exp();
        exp_res[0][0] = 16'd3;
        #1;
        check("flip_out_m", 32'(out_m), 32'd1);
        check("flip_out_n", 32'(out_n), 32'd1);
        check("flip_valid", 32'(valid), 32'd1);
        check_grid("flip_res");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
